// File: rtl/reorder_pkg.sv
// rtl/reorder_pkg.sv - shared types and index helpers for the line reorder controller.
package reorder_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_e;

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Even samples (L) pack into the lower half of a bank, odd samples (H) into the upper half.
    function automatic int unsigned perm(input int unsigned i, input int unsigned line_width);
        return i[0] ? (line_width / 2 + (i >> 1)) : (i >> 1);
    endfunction

endpackage

// File: rtl/reorder_skid2.sv
// rtl/reorder_skid2.sv - 2-entry fall-through valid/ready buffer for read data and last flag.
module reorder_skid2 #(
    parameter int Width = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] in_data,
    input  logic             in_valid,
    output logic [Width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [Width-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             store;
    logic             deq;

    // When empty, arriving data is presented directly so a read costs no extra cycle.
    assign out_valid = (count != 2'd0) || in_valid;
    assign out_data  = (count != 2'd0) ? mem[rd_ptr] : in_data;
    assign deq       = (count != 2'd0) && out_ready;
    assign store     = in_valid && !((count == 2'd0) && out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) begin
                wr_ptr <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, store} - {1'b0, deq};
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/line_deinterleave_ctrl.sv
// rtl/line_deinterleave_ctrl.sv - ping-pong Bram write/read controller turning L,H,L,H lines
// into all-L then all-H lines.
module line_deinterleave_ctrl
    import reorder_pkg::*;
#(
    parameter  int DataWidth = 16,
    parameter  int LineWidth = 256,
    localparam int Size      = 2 * LineWidth,
    localparam int AddrWidth = addr_width(Size)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [DataWidth-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 bram_ena,
    output logic                 bram_wea,
    output logic [AddrWidth-1:0] bram_addra,
    output logic [DataWidth-1:0] bram_dina,
    output logic                 bram_enb,
    output logic [AddrWidth-1:0] bram_addrb,
    input  logic [DataWidth-1:0] bram_doutb
);

    localparam int                  CntWidth = AddrWidth - 1;
    localparam logic [CntWidth-1:0] LastIdx  = CntWidth'(LineWidth - 1);

    bank_state_e         bank_state [2];
    logic                wbank;
    logic                rbank;
    logic [CntWidth-1:0] wcnt;
    logic [CntWidth-1:0] rcnt;
    logic [CntWidth-1:0] wr_slot;
    logic                wr_fire;
    logic                wr_end;
    logic                rd_issue;
    logic                rd_end;
    logic                rd_pending;
    logic                rd_last;
    logic                pop;
    logic                credit;
    logic [1:0]          skid_count;
    logic [2:0]          occupancy;
    logic [DataWidth:0]  skid_out;

    assign s_ready = !rst && (bank_state[wbank] == EMPTY);
    assign wr_fire = s_valid && s_ready;
    assign wr_end  = (wcnt == LastIdx);
    assign wr_slot = CntWidth'(perm(32'(wcnt), LineWidth));

    assign bram_ena   = wr_fire;
    assign bram_wea   = wr_fire;
    assign bram_addra = {wbank, wr_slot};
    assign bram_dina  = s_data;

    // Occupancy is what the skid will hold after this cycle's pop and landing read; a new
    // issue lands one cycle later, so at most one entry may be committed for it to fit.
    assign pop       = m_valid && m_ready;
    assign occupancy = 3'(skid_count) + 3'(rd_pending) - 3'(pop);
    assign credit    = (occupancy < 3'd2);
    assign rd_issue  = (bank_state[rbank] == FULL) && credit;
    assign rd_end    = (rcnt == LastIdx);

    assign bram_enb   = rd_issue;
    assign bram_addrb = {rbank, rcnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank         <= 1'b0;
            rbank         <= 1'b0;
            wcnt          <= '0;
            rcnt          <= '0;
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            rd_pending    <= 1'b0;
            rd_last       <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_end) begin
                    bank_state[wbank] <= FULL;
                    wbank             <= ~wbank;
                    wcnt              <= '0;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            // The writer only touches EMPTY banks and the reader only FULL ones, so these never collide.
            if (rd_issue) begin
                if (rd_end) begin
                    bank_state[rbank] <= EMPTY;
                    rbank             <= ~rbank;
                    rcnt              <= '0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
            rd_pending <= rd_issue;
            rd_last    <= rd_issue && rd_end;
        end
    end

    reorder_skid2 #(
        .Width(DataWidth + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({bram_doutb, rd_last}),
        .in_valid (rd_pending),
        .out_data (skid_out),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .count    (skid_count)
    );

    assign m_data = skid_out[DataWidth:1];
    assign m_last = skid_out[0];

endmodule

// File: tb/tb_line_deinterleave_ctrl.sv
// tb/tb_line_deinterleave_ctrl.sv - directed bench for the line deinterleave controller
// (LineWidth 8 main instance, LineWidth 4 secondary instance).
module tb_line_deinterleave_ctrl;

    localparam int DW  = 16;
    localparam int LW  = 8;
    localparam int AW  = 4;
    localparam int LW4 = 4;
    localparam int AW4 = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] s_data  = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic          bram_ena, bram_wea, bram_enb;
    logic [AW-1:0] bram_addra, bram_addrb;
    logic [DW-1:0] bram_dina, bram_doutb;
    logic [DW-1:0] bram [16];

    line_deinterleave_ctrl #(.DataWidth(DW), .LineWidth(LW)) u_dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
        .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
    );

    always @(posedge clk) begin
        if (bram_ena && bram_wea) bram[bram_addra] <= bram_dina;
        if (bram_enb) bram_doutb <= bram[bram_addrb];
    end

    logic [DW-1:0]  s4_data  = '0;
    logic           s4_valid = 1'b0;
    logic           s4_ready;
    logic [DW-1:0]  m4_data;
    logic           m4_valid;
    logic           m4_ready = 1'b1;
    logic           m4_last;
    logic           b4_ena, b4_wea, b4_enb;
    logic [AW4-1:0] b4_addra, b4_addrb;
    logic [DW-1:0]  b4_dina, b4_doutb;
    logic [DW-1:0]  bram4 [8];

    line_deinterleave_ctrl #(.DataWidth(DW), .LineWidth(LW4)) u_dut4 (
        .clk(clk), .rst(rst),
        .s_data(s4_data), .s_valid(s4_valid), .s_ready(s4_ready),
        .m_data(m4_data), .m_valid(m4_valid), .m_ready(m4_ready), .m_last(m4_last),
        .bram_ena(b4_ena), .bram_wea(b4_wea), .bram_addra(b4_addra), .bram_dina(b4_dina),
        .bram_enb(b4_enb), .bram_addrb(b4_addrb), .bram_doutb(b4_doutb)
    );

    always @(posedge clk) begin
        if (b4_ena && b4_wea) bram4[b4_addra] <= b4_dina;
        if (b4_enb) b4_doutb <= bram4[b4_addrb];
    end

    // 0: m_ready low, 1: m_ready high, 2: m_ready random
    int rdy_mode = 1;
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [DW-1:0] out_data_q [$];
    logic          out_last_q [$];
    int            out_cyc_q  [$];
    logic [DW-1:0] out4_data_q [$];
    logic          out4_last_q [$];
    int            stall_viol = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    initial forever begin
        @(negedge clk);
        if (prev_stall && !rst && !(m_valid === 1'b1 && m_data === prev_data && m_last === prev_last))
            stall_viol++;
        prev_stall = (m_valid === 1'b1) && !m_ready && !rst;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_valid === 1'b1 && m_ready) begin
            out_data_q.push_back(m_data);
            out_last_q.push_back(m_last);
            out_cyc_q.push_back(cyc);
        end
        if (m4_valid === 1'b1 && m4_ready) begin
            out4_data_q.push_back(m4_data);
            out4_last_q.push_back(m4_last);
        end
    end

    function automatic logic [DW-1:0] exp_val(input int base, input int k, input int lw);
        int src;
        src = (k < lw / 2) ? 2 * k : 2 * (k - lw / 2) + 1;
        return DW'(base + src);
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        s_valid  = 1'b0;
        s4_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_data_q.delete();
        out_last_q.delete();
        out_cyc_q.delete();
        out4_data_q.delete();
        out4_last_q.delete();
        stall_viol = 0;
    endtask

    task automatic push_stream(input int first, input int n, input int budget, input bit rand_valid,
                               output int accepted, output int t_last);
        accepted = 0;
        t_last   = -1;
        for (int c = 0; c < budget && accepted < n; c++) begin
            @(posedge clk); #1;
            s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = DW'(first + accepted);
            @(negedge clk);
            if (s_valid && s_ready) begin
                accepted++;
                t_last = cyc;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int c = 0;
        while (out_data_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (out_data_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d outputs, expected %0d", name, out_data_q.size(), n);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_last, bram_ena, bram_wea, bram_enb, s4_ready, m4_valid} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {s_ready, m_valid, m_last, bram_ena, bram_wea, bram_enb, s4_ready, m4_valid});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got s_ready=%b m_valid=%b expected s_ready=1 m_valid=0", s_ready, m_valid);
        end
    endtask

    task automatic test_single_line();
        int acc, t_last;
        apply_reset();
        rdy_mode = 1;
        push_stream(0, LW, 20, 1'b0, acc, t_last);
        wait_out(LW, 20, "single_line");
        checks++;
        if (out_cyc_q.size() < 1 || out_cyc_q[0] - t_last !== 2) begin
            errors++;
            $display("FAIL single_line_latency: got %0d cycles expected 2",
                     out_cyc_q.size() > 0 ? out_cyc_q[0] - t_last : -1);
        end
        for (int j = 0; j < LW && j < out_data_q.size(); j++) begin
            checks++;
            if (out_data_q[j] !== exp_val(0, j, LW) || out_last_q[j] !== (j == LW - 1)) begin
                errors++;
                $display("FAIL single_line[%0d]: got %0d/last=%b expected %0d/last=%b",
                         j, out_data_q[j], out_last_q[j], exp_val(0, j, LW), j == LW - 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc, t_last;
        int issue_cyc  = -1;
        int sready_cyc = -1;
        apply_reset();
        rdy_mode = 0;
        push_stream(0, 24, 40, 1'b0, acc, t_last);
        @(negedge clk);
        checks++;
        if (acc !== 2 * LW || s_ready !== 1'b0 || out_data_q.size() !== 0) begin
            errors++;
            $display("FAIL backpressure_fill: got accepted=%0d s_ready=%b popped=%0d expected 16/0/0",
                     acc, s_ready, out_data_q.size());
        end
        rdy_mode = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bram_enb && bram_addrb == AW'(LW - 1) && issue_cyc < 0) issue_cyc = cyc;
            if (s_ready && sready_cyc < 0) sready_cyc = cyc;
        end
        checks++;
        if (issue_cyc < 0 || sready_cyc !== issue_cyc + 1) begin
            errors++;
            $display("FAIL backpressure_reopen: got s_ready cycle %0d expected %0d", sready_cyc, issue_cyc + 1);
        end
        wait_out(2 * LW, 20, "backpressure");
        for (int j = 0; j < 2 * LW && j < out_data_q.size(); j++) begin
            checks++;
            if (out_data_q[j] !== exp_val((j / LW) * LW, j % LW, LW) || out_last_q[j] !== (j % LW == LW - 1)) begin
                errors++;
                $display("FAIL backpressure[%0d]: got %0d/last=%b expected %0d/last=%b", j, out_data_q[j],
                         out_last_q[j], exp_val((j / LW) * LW, j % LW, LW), j % LW == LW - 1);
            end
        end
    endtask

    task automatic test_continuous();
        int acc, t_last;
        apply_reset();
        rdy_mode = 1;
        push_stream(100, 64, 64, 1'b0, acc, t_last);
        checks++;
        if (acc !== 64) begin
            errors++;
            $display("FAIL continuous_in_rate: got %0d accepted in 64 cycles expected 64", acc);
        end
        wait_out(64, 30, "continuous");
        checks++;
        if (out_cyc_q.size() < 64 || out_cyc_q[63] - out_cyc_q[0] !== 63) begin
            errors++;
            $display("FAIL continuous_out_rate: got span %0d expected 63",
                     out_cyc_q.size() >= 64 ? out_cyc_q[63] - out_cyc_q[0] : -1);
        end
        for (int j = 0; j < 64 && j < out_data_q.size(); j++) begin
            checks++;
            if (out_data_q[j] !== exp_val(100 + (j / LW) * LW, j % LW, LW) || out_last_q[j] !== (j % LW == LW - 1)) begin
                errors++;
                $display("FAIL continuous[%0d]: got %0d expected %0d", j, out_data_q[j],
                         exp_val(100 + (j / LW) * LW, j % LW, LW));
            end
        end
    endtask

    task automatic test_random_ready();
        int acc, t_last;
        int n = 100 * LW;
        apply_reset();
        rdy_mode = 2;
        push_stream(1000, n, 20000, 1'b1, acc, t_last);
        checks++;
        if (acc !== n) begin
            errors++;
            $display("FAIL random_accept: got %0d expected %0d", acc, n);
        end
        wait_out(n, 400, "random");
        for (int j = 0; j < n && j < out_data_q.size(); j++) begin
            checks++;
            if (out_data_q[j] !== exp_val(1000 + (j / LW) * LW, j % LW, LW) || out_last_q[j] !== (j % LW == LW - 1)) begin
                errors++;
                $display("FAIL random[%0d]: got %0d/last=%b expected %0d", j, out_data_q[j], out_last_q[j],
                         exp_val(1000 + (j / LW) * LW, j % LW, LW));
            end
        end
        checks++;
        if (stall_viol !== 0) begin
            errors++;
            $display("FAIL random_stall_stable: got %0d violations expected 0", stall_viol);
        end
        rdy_mode = 1;
    endtask

    task automatic test_reset_mid_line();
        int acc, t_last;
        apply_reset();
        rdy_mode = 1;
        push_stream(500, 5, 5, 1'b0, acc, t_last);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_last, bram_ena, bram_wea, bram_enb} !== 6'b0) begin
            errors++;
            $display("FAIL midline_reset_outputs: got %b expected 000000",
                     {s_ready, m_valid, m_last, bram_ena, bram_wea, bram_enb});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_data_q.delete();
        out_last_q.delete();
        out_cyc_q.delete();
        push_stream(600, LW, 20, 1'b0, acc, t_last);
        wait_out(LW, 20, "midline");
        repeat (10) @(negedge clk);
        checks++;
        if (out_data_q.size() !== LW) begin
            errors++;
            $display("FAIL midline_count: got %0d outputs expected %0d", out_data_q.size(), LW);
        end
        for (int j = 0; j < LW && j < out_data_q.size(); j++) begin
            checks++;
            if (out_data_q[j] !== exp_val(600, j, LW) || out_last_q[j] !== (j == LW - 1)) begin
                errors++;
                $display("FAIL midline[%0d]: got %0d expected %0d", j, out_data_q[j], exp_val(600, j, LW));
            end
        end
    endtask

    task automatic test_line_width4();
        logic [DW-1:0] vin  [4] = '{16'd9, 16'd8, 16'd7, 16'd6};
        logic [DW-1:0] vexp [4] = '{16'd9, 16'd7, 16'd8, 16'd6};
        int idx = 0;
        int c   = 0;
        apply_reset();
        while (idx < 4 && c < 20) begin
            @(posedge clk); #1;
            s4_valid = 1'b1;
            s4_data  = vin[idx];
            @(negedge clk);
            if (s4_ready) idx++;
            c++;
        end
        @(posedge clk); #1;
        s4_valid = 1'b0;
        c = 0;
        while (out4_data_q.size() < 4 && c < 20) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (out4_data_q.size() !== 4) begin
            errors++;
            $display("FAIL lw4_count: got %0d outputs expected 4", out4_data_q.size());
        end
        for (int j = 0; j < 4 && j < out4_data_q.size(); j++) begin
            checks++;
            if (out4_data_q[j] !== vexp[j] || out4_last_q[j] !== (j == 3)) begin
                errors++;
                $display("FAIL lw4[%0d]: got %0d/last=%b expected %0d/last=%b", j, out4_data_q[j],
                         out4_last_q[j], vexp[j], j == 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_backpressure();
        test_continuous();
        test_random_ready();
        test_reset_mid_line();
        test_line_width4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
